// File: rtl/posit_defines.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : posit_defines (package)
//  Description : Shared type definitions for the posit arithmetic blocks.
//                Holds the sequential leading-zero counter state encoding
//                and a small width helper used for index registers.
//  Revision    : 1.0 - initial release
// ============================================================================
package posit_defines;

    // Sequential leading-zero counter control states.
    typedef enum logic [1:0] {
        LZC_IDLE = 2'd0,
        LZC_SCAN = 2'd1,
        LZC_DONE = 2'd2
    } lzc_state_t;

    // Bits needed to index n items, never less than one so that a register
    // exists even when there is a single item.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : posit_defines
`default_nettype wire

// File: rtl/lzc_seq_lzd.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : LZD_N
//  Description : Combinational leading-zero detector for a C_N-bit word.
//                Returns the number of zeros above the most significant set
//                bit. The result for an all-zero word is don't-care; the
//                caller tests for zero on its own.
//  Ports       : in_i     [C_N-1:0]          word to examine, bit C_N-1 = MSB
//                count_o  [$clog2(C_N)-1:0]  leading-zero count, 0..C_N-1
//  Revision    : 1.0 - initial release
// ============================================================================
module LZD_N #(
    parameter int C_N = 64
) (
    input  logic [C_N-1:0]          in_i,
    output logic [$clog2(C_N)-1:0]  count_o
);

    localparam int C_CW = $clog2(C_N);

    logic w_found;

    // Priority scan from the MSB; the first set bit met fixes the count.
    always_comb begin
        w_found = 1'b0;
        count_o = '0;
        for (int i = C_N - 1; i >= 0; i--) begin
            if (!w_found && in_i[i]) begin
                count_o = C_CW'(C_N - 1 - i);
                w_found = 1'b1;
            end
        end
    end

endmodule : LZD_N
`default_nettype wire

// File: rtl/lzc_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : lzc_seq
//  Description : Sequential leading-zero counter. An accepted operand is
//                scanned one C_CHUNK-bit chunk per cycle, MSB chunk first,
//                through a single shared LZD_N. The result is held until the
//                consumer takes it.
//  Ports       : clk        clock, rising edge
//                rst_n      synchronous active-low reset
//                in_valid   operand offered
//                in_ready   block idle and able to accept
//                in_data    [C_W-1:0] operand, bit C_W-1 = MSB
//                out_valid  result available
//                out_ready  consumer accepts the result
//                out_count  [$clog2(C_W):0] leading-zero count, 0..C_W
//                out_zero   operand was all zeros
//                busy       scan in progress or result pending
//  Parameters  : C_W must be a multiple of C_CHUNK; C_CHUNK a power of two
//                and at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module lzc_seq
    import posit_defines::*;
#(
    parameter int C_W     = 256,
    parameter int C_CHUNK = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [C_W-1:0]        in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [$clog2(C_W):0]  out_count,
    output logic                  out_zero,
    output logic                  busy
);

    localparam int C_N_CHUNKS = C_W / C_CHUNK;
    localparam int C_K_W      = clog2_min1(C_N_CHUNKS);
    localparam int C_N_SLOTS  = 1 << C_K_W;
    localparam int C_CNT_W    = $clog2(C_W) + 1;
    localparam int C_LZD_W    = $clog2(C_CHUNK);

    localparam logic [C_K_W-1:0]   C_K_LAST = C_K_W'(C_N_CHUNKS - 1);
    localparam logic [C_CNT_W-1:0] C_STEP   = C_CNT_W'(C_CHUNK);
    localparam logic [C_CNT_W-1:0] C_FULL   = C_CNT_W'(C_W);

    // ------------------------------------------------------------------
    //  State
    // ------------------------------------------------------------------
    lzc_state_t           state_q, state_d;
    logic [C_K_W-1:0]     k_q, k_d;
    logic [C_CNT_W-1:0]   acc_q, acc_d;
    logic [C_W-1:0]       data_q, data_d;
    logic [C_CNT_W-1:0]   count_q, count_d;
    logic                 zero_q, zero_d;

    // ------------------------------------------------------------------
    //  Chunk multiplexer
    //  The slot table is padded to a power of two so that every value of
    //  k_q addresses a defined entry; the padding slots are never reached.
    // ------------------------------------------------------------------
    logic [C_CHUNK-1:0]   w_chunks [C_N_SLOTS];
    logic [C_CHUNK-1:0]   w_chunk;
    logic                 w_chunk_nz;
    logic [C_LZD_W-1:0]   w_lzd;

    for (genvar j = 0; j < C_N_SLOTS; j++) begin : g_chunk
        if (j < C_N_CHUNKS) begin : g_real
            assign w_chunks[j] = data_q[C_W-1-j*C_CHUNK -: C_CHUNK];
        end else begin : g_pad
            assign w_chunks[j] = '0;
        end
    end

    assign w_chunk    = w_chunks[k_q];
    // Zero test is done locally so the detector only has to supply a count.
    assign w_chunk_nz = |w_chunk;

    LZD_N #(
        .C_N     (C_CHUNK)
    ) u_lzd (
        .in_i    (w_chunk),
        .count_o (w_lzd)
    );

    // ------------------------------------------------------------------
    //  State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LZC_IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    // ------------------------------------------------------------------
    //  Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        data_d  = data_q;
        count_d = count_q;
        zero_d  = zero_q;

        unique case (state_q)
            LZC_IDLE: begin
                if (in_valid) begin
                    // Operand is captured here so later changes on in_data
                    // cannot disturb the scan.
                    data_d  = in_data;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = LZC_SCAN;
                end
            end

            LZC_SCAN: begin
                if (w_chunk_nz) begin
                    count_d = acc_q + C_CNT_W'(w_lzd);
                    zero_d  = 1'b0;
                    state_d = LZC_DONE;
                end else if (k_q == C_K_LAST) begin
                    count_d = C_FULL;
                    zero_d  = 1'b1;
                    state_d = LZC_DONE;
                end else begin
                    acc_d = acc_q + C_STEP;
                    k_d   = k_q + 1'b1;
                end
            end

            LZC_DONE: begin
                if (out_ready) begin
                    state_d = LZC_IDLE;
                end
            end

            default: begin
                state_d = LZC_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    //  Outputs
    // ------------------------------------------------------------------
    // rst_n gating keeps in_ready low during reset even before the first
    // reset edge has forced the state register to IDLE.
    assign in_ready  = rst_n && (state_q == LZC_IDLE);
    assign out_valid = (state_q == LZC_DONE);
    assign busy      = (state_q == LZC_SCAN) || (state_q == LZC_DONE);
    assign out_count = count_q;
    assign out_zero  = zero_q;

endmodule : lzc_seq
`default_nettype wire

// File: tb/tb_lzc_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_lzc_seq
//  Description : Self-checking bench for lzc_seq (C_W=256, C_CHUNK=64).
//                Directed cases plus randomized operands compared against a
//                bit-by-bit leading-zero reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lzc_seq;

    localparam int C_W     = 256;
    localparam int C_CHUNK = 64;
    localparam int C_NCH   = C_W / C_CHUNK;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [C_W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [8:0]     out_count;
    logic           out_zero;
    logic           busy;

    int n_cmp;
    int n_err;

    lzc_seq #(
        .C_W       (C_W),
        .C_CHUNK   (C_CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: count zeros from the MSB down to the first one.
    function automatic int lzc_ref(input logic [C_W-1:0] v);
        for (int i = C_W - 1; i >= 0; i--) begin
            if (v[i]) return C_W - 1 - i;
        end
        return C_W;
    endfunction

    function automatic logic [C_W-1:0] rand_word();
        logic [C_W-1:0] v;
        for (int w = 0; w < C_W / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // Random operand with exactly lz leading zeros.
    function automatic logic [C_W-1:0] make_operand(input int lz);
        logic [C_W-1:0] v;
        v = rand_word();
        if (lz >= C_W) return '0;
        for (int i = 0; i < lz; i++) v[C_W-1-i] = 1'b0;
        v[C_W-1-lz] = 1'b1;
        return v;
    endfunction

    // One complete transaction: offer d, measure latency, hold the result for
    // 'stall' cycles with in_valid pulsed, then take it.
    task automatic run_op(input logic [C_W-1:0] d, input int stall, input string tag);
        int  lat;
        bit  seen;
        int  exp_lz;
        int  exp_k;
        exp_lz = lzc_ref(d);
        exp_k  = (exp_lz >= C_W) ? (C_NCH - 1) : (exp_lz / C_CHUNK);

        @(negedge clk);
        check_eq({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 12) begin
            if (out_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check_eq({tag, "_valid_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_k + 2));
        check_eq({tag, "_count"}, 32'(out_count), 32'(exp_lz));
        check_eq({tag, "_zero"}, 32'(out_zero), 32'(exp_lz == C_W));
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);

        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_data  = rand_word();
            @(negedge clk);
            check_eq({tag, "_hold_count"}, 32'(out_count), 32'(exp_lz));
            check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check_eq({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_post_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int idx   [$];
        int cnt   [$];
        bit saw;
        int ready_at3;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_count", 32'(out_count), 32'd0);
        check_eq("rst_zero", 32'(out_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_release_in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        run_op(256'd1 << 255, 0, "msb");
        run_op(256'd1 << 100, 0, "bit100");
        run_op(256'd0,        0, "allzero");
        run_op(256'd1,        3, "lsb_stall");

        // Back-to-back with in_valid held and out_ready high
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 256'd1 << 200;
        out_ready = 1'b1;
        ready_at3 = 0;
        @(posedge clk);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) in_data = 256'd1 << 63;
            if (n == 3) ready_at3 = int'(in_ready);
            if (out_valid) begin
                idx.push_back(n);
                cnt.push_back(int'(out_count));
                if (idx.size() == 2) in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("b2b_results", 32'(idx.size()), 32'd2);
        check_eq("b2b_in_ready_gap", 32'(ready_at3), 32'd1);
        if (idx.size() == 2) begin
            check_eq("b2b_first_at", 32'(idx[0]), 32'd2);
            check_eq("b2b_first_count", 32'(cnt[0]), 32'd55);
            check_eq("b2b_second_at", 32'(idx[1]), 32'd8);
            check_eq("b2b_second_count", 32'(cnt[1]), 32'd192);
        end

        // Reset in the middle of a scan
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = '0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("rscan_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rscan_in_ready_low", 32'(in_ready), 32'd0);
        check_eq("rscan_busy_clr", 32'(busy), 32'd0);
        check_eq("rscan_count_clr", 32'(out_count), 32'd0);
        rst_n = 1'b1;
        saw   = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        check_eq("rscan_no_result", 32'(saw), 32'd0);
        check_eq("rscan_in_ready", 32'(in_ready), 32'd1);

        // Randomized operands, with chunk boundaries favoured
        for (int t = 0; t < 40; t++) begin
            int lz;
            if ($urandom_range(0, 3) == 0)
                lz = 64 * $urandom_range(0, 4) - $urandom_range(0, 1);
            else
                lz = $urandom_range(0, C_W);
            if (lz < 0) lz = 0;
            run_op(make_operand(lz), $urandom_range(0, 3), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_lzc_seq
`default_nettype wire

// File: doc/lzc_seq.md
LZC_SEQ -- requirements
Module: lzc_seq

Interface
REQ-001 Parameter C_W, default 256: operand width in bits; SHALL be an integer multiple of C_CHUNK.
REQ-002 Parameter C_CHUNK, default 64: chunk width scanned per cycle; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 in_valid  input  1  operand offered.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 in_data  input  C_W  operand; bit C_W-1 is the MSB.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_count  output  $clog2(C_W)+1  leading-zero count, range 0..C_W.
REQ-011 out_zero  output  1  operand was all zeros.
REQ-012 busy  output  1  high in SCAN or DONE.

Function
REQ-013 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-014 in_ready SHALL equal (state==IDLE) and SHALL be 0 while rst_n is low.
REQ-015 An input handshake (in_valid and in_ready on the same edge) SHALL register in_data, set chunk index k=0 (MSB chunk), clear the accumulator and enter SCAN.
REQ-016 In SCAN, chunk k = in_data[C_W-1-k*C_CHUNK -: C_CHUNK] SHALL be examined once per cycle.
REQ-017 Nonzero chunk: out_count SHALL be set to acc + LZD(chunk), out_zero to 0, and the FSM SHALL enter DONE.
REQ-018 Zero chunk that is not the last: acc SHALL be incremented by C_CHUNK and k incremented, staying in SCAN.
REQ-019 Zero last chunk (k = C_W/C_CHUNK-1): out_count SHALL be set to C_W, out_zero to 1, and the FSM SHALL enter DONE.
REQ-020 out_valid SHALL equal (state==DONE); the first result cycle SHALL be k+2 cycles after the accept edge, where k is the index of the first nonzero chunk (k = C_W/C_CHUNK-1 for an all-zero operand).
REQ-021 In DONE, out_count and out_zero SHALL hold stable until out_ready is high; on that output handshake the FSM SHALL return to IDLE.
REQ-022 in_valid SHALL be ignored outside IDLE; there is no operand bypass, so the next accept can occur at the earliest one cycle after the output handshake.
REQ-023 in_data changes after acceptance SHALL NOT affect the result.
REQ-024 out_count and out_zero SHALL be driven from registers with no combinational path from the inputs.

Reset
REQ-025 While rst_n is low at a clk edge, the block SHALL enter IDLE and clear out_valid, out_count, out_zero, busy, acc and k to 0.
REQ-026 Reset during SCAN or DONE SHALL abort the operation with no output handshake; after release, in_ready SHALL be 1 and out_valid SHALL be 0.

Structure
REQ-027 The state enum type lzc_state_t SHALL be added to the shared posit_defines package; count/index widths are local parameters.
REQ-028 Exactly one LZD_N sub-module instance (C_N=C_CHUNK) SHALL be fed by a chunk multiplexer indexed by k.
REQ-029 The chunk all-zero test SHALL be a local reduction-OR and SHALL NOT depend on sub-module validity outputs.

Verification (C_W=256, C_CHUNK=64)
REQ-030 in_data=1<<255, out_ready=1 -> out_count=0, out_zero=0, out_valid 2 cycles after accept.
REQ-031 in_data=1<<100 -> k=2, out_count=155, out_zero=0, out_valid 4 cycles after accept.
REQ-032 in_data=0 -> out_count=256, out_zero=1, out_valid 5 cycles after accept.
REQ-033 in_data=1<<0, out_ready low for 3 cycles in DONE, in_valid pulsed -> out_count=255 stable, in_ready=0, no extra accept, IDLE after the handshake.
REQ-034 rst_n low for 1 cycle mid-SCAN -> out_valid=0 thereafter, in_ready=1 after release, no result emitted.
REQ-035 Operands 1<<200 then 1<<63 with in_valid held and out_ready=1 -> results 55 then 192; second accept one cycle after the first output handshake.
